diad_trace_buf: RTL and testbench
=================================

Name: diad_trace_buf

Overview:
- On-chip retirement trace capture for the diad pipeline.
- Records the PC, instruction and cycle tick of every instruction leaving the RO stage into a circular buffer.
- Freezes the buffer a programmable number of entries after a trigger, then lets a debug reader drain it oldest-first.
- Sits beside the diad core, fed by the RO-stage PC/instr buses, and provides the in-silicon counterpart of the simulation PC/INSTR trace.

Parameters:
- PC_W, 24, width of captured PC.
- INSTR_W, 24, width of captured instruction.
- DEPTH, 16, buffer entries; must be a power of 2, at least 4.
- TICK_W, 16, width of the free-running cycle tick stored per entry.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  synchronous active-high reset.
- iw_valid  in  1  RO stage retires an instruction this cycle.
- iw_pc  in  PC_W  RO-stage PC.
- iw_instr  in  INSTR_W  RO-stage instruction.
- iw_arm  in  1  pulse: clear the buffer and start capture.
- iw_trig  in  1  pulse: trigger event.
- iw_post  in  $clog2(DEPTH)+1  number of entries to capture after the trigger.
- iw_rd_en  in  1  pop request.
- ow_rd_valid  out  1  read data valid.
- ow_rd_pc  out  PC_W  popped PC.
- ow_rd_instr  out  INSTR_W  popped instruction.
- ow_rd_tick  out  TICK_W  popped tick.
- ow_state  out  2  current FSM state.
- ow_count  out  $clog2(DEPTH)+1  entries held.
- ow_overflow  out  1  older entries were overwritten.

Behaviour:
- Reset: state IDLE, pointers 0, ow_count 0, ow_overflow 0, ow_rd_valid 0, rd data 0, tick 0.
- Tick counter:
  - Increments every cycle, including while in reset release, and wraps modulo 2^TICK_W.
  - Each entry stores the tick value of its capture cycle.
- State encoding: IDLE=0, ARMED=1, POST=2, DONE=3.
- IDLE:
  - Nothing captured; iw_trig ignored.
  - iw_arm -> ARMED with count, pointers and overflow cleared on the next edge.
- ARMED:
  - Every iw_valid cycle writes one entry at wr_ptr; wr_ptr increments and wraps.
  - count saturates at DEPTH; a write at count==DEPTH sets ow_overflow (sticky until arm/reset).
  - On iw_trig, the same-cycle valid entry is captured as the trigger entry, and a post counter is loaded with min(iw_post, DEPTH-1).
  - If the loaded value is 0 -> DONE; otherwise -> POST.
- POST:
  - Captures as in ARMED; each captured entry decrements the post counter.
  - The write that brings it to 0 -> DONE.
  - iw_trig ignored.
- DONE:
  - No writes, buffer frozen.
  - The read pointer starts at wr_ptr - count (mod DEPTH), i.e. the oldest entry.
- Reads:
  - iw_rd_en is accepted only in DONE with count>0.
  - ow_rd_valid is high exactly one cycle later, with that entry's data; the pointer advances and count decrements.
  - Back-to-back pops give one entry per cycle.
  - rd_en at count==0, or outside DONE: no effect, ow_rd_valid 0.
  - Rd data holds its last value while ow_rd_valid is 0.
- iw_arm in any state restarts capture (-> ARMED, cleared). A same-cycle iw_rd_en is dropped.
- iw_arm and iw_trig in the same cycle: arm wins, trig ignored.
- iw_rst mid-capture or mid-drain: immediate return to reset values on that edge.

Optional Feature:
- DIAD_TRACE_FILTER_EN:
  - Adds ports iw_pc_lo and iw_pc_hi (PC_W, in).
  - A retirement is captured only when iw_valid is high and iw_pc_lo <= iw_pc <= iw_pc_hi (unsigned, inclusive).
  - Filtered-out retirements neither write nor decrement the post counter.
  - iw_trig is still honoured on filtered cycles; the trigger entry is simply absent.
- Without the macro: no extra ports, and every valid retirement is captured.

Decomposition:
- Package diad_trace_pkg holds:
  - state encoding constants: ST_IDLE, ST_ARMED, ST_POST, ST_DONE;
  - the default widths;
  - the packed entry layout {tick, pc, instr} with its total width function.
- Sub-module diad_trace_ram: DEPTH x entry simple dual-port RAM with one write port and one registered read port (1-cycle latency). It supplies the read latency above.

Test Plan:
- Reset, then arm; 5 valid retirements PC 0x000000..0x000004; trig with iw_post=0 on the 5th -> DONE, count=5, overflow=0; 5 pops return PCs 0..4 oldest-first with increasing ticks.
- Arm; 20 valid retirements (DEPTH=16), trig with post=0 on the 20th -> count=16, overflow=1; pops return retirements 5..20.
- Arm; trig with iw_post=3 on retirement 10, valid on alternating cycles -> state 2 for exactly 3 further valid writes, then 3; last popped entry is retirement 13.
- In DONE with count=2, assert rd_en for 4 consecutive cycles -> ow_rd_valid high for 2 cycles only, count=0, no pointer movement after that.
- Assert arm and trig in the same cycle -> state ARMED, count 0. Assert iw_rst while in POST -> IDLE with all outputs 0 on the next edge.
- With DIAD_TRACE_FILTER_EN, lo=0x100, hi=0x1FF, PCs 0x0FF, 0x100, 0x1FF, 0x200 -> only 0x100 and 0x1FF captured.

Source files
------------

// File: rtl/diad_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : diad_trace_pkg
// Purpose  : Shared state encoding, default widths and entry layout for the
//            diad retirement trace buffer.
// Revision : 1.0 - initial release
// ============================================================================
package diad_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_pc_w_def    = 24;
    localparam int c_instr_w_def = 24;
    localparam int c_depth_def   = 16;
    localparam int c_tick_w_def  = 16;

    // Entry layout, MSB first: {tick, pc, instr}
    typedef struct packed {
        logic [c_tick_w_def-1:0]  tick;
        logic [c_pc_w_def-1:0]    pc;
        logic [c_instr_w_def-1:0] instr;
    } entry_t;

    function automatic int entry_w(input int pc_w, input int instr_w, input int tick_w);
        return tick_w + pc_w + instr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/diad_trace_ram.sv
`default_nettype none
// ============================================================================
// Module   : diad_trace_ram
// Purpose  : DEPTH x WIDTH simple dual-port RAM, one write port and one
//            registered read port (1-cycle latency, holds when not read).
// Revision : 1.0 - initial release
// ============================================================================
module diad_trace_ram
    import diad_trace_pkg::*;
#(
    parameter int DEPTH = c_depth_def,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/diad_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : diad_trace_buf
// Purpose  : Retirement trace capture with trigger/post-count freeze and
//            oldest-first drain. Optional PC window filter: DIAD_TRACE_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module diad_trace_buf
    import diad_trace_pkg::*;
#(
    parameter int PC_W    = c_pc_w_def,
    parameter int INSTR_W = c_instr_w_def,
    parameter int DEPTH   = c_depth_def,
    parameter int TICK_W  = c_tick_w_def
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic                   iw_valid,
    input  logic [PC_W-1:0]        iw_pc,
    input  logic [INSTR_W-1:0]     iw_instr,
`ifdef DIAD_TRACE_FILTER_EN
    input  logic [PC_W-1:0]        iw_pc_lo,
    input  logic [PC_W-1:0]        iw_pc_hi,
`endif
    input  logic                   iw_arm,
    input  logic                   iw_trig,
    input  logic [$clog2(DEPTH):0] iw_post,
    input  logic                   iw_rd_en,
    output logic                   ow_rd_valid,
    output logic [PC_W-1:0]        ow_rd_pc,
    output logic [INSTR_W-1:0]     ow_rd_instr,
    output logic [TICK_W-1:0]      ow_rd_tick,
    output logic [1:0]             ow_state,
    output logic [$clog2(DEPTH):0] ow_count,
    output logic                   ow_overflow
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_ew = entry_w(PC_W, INSTR_W, TICK_W);
    localparam logic [c_cw-1:0] c_full     = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_post_max = c_cw'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TICK_W-1:0] r_tick;
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_cw-1:0]   r_count;
    logic [c_cw-1:0]   r_post;
    logic              r_overflow;
    logic              r_rd_valid;
    logic              w_in_range;
    logic              w_capture;
    logic              w_trig_take;
    logic              w_pop;
    logic [c_cw-1:0]   w_post_ld;
    logic [c_aw-1:0]   w_rd_addr;
    logic [c_ew-1:0]   w_rd_entry;

`ifdef DIAD_TRACE_FILTER_EN
    assign w_in_range = (iw_pc >= iw_pc_lo) && (iw_pc <= iw_pc_hi);
`else
    assign w_in_range = 1'b1;
`endif

    // Arm takes priority over everything issued in the same cycle.
    assign w_capture   = iw_valid && w_in_range && !iw_arm &&
                         ((r_state == ST_ARMED) || (r_state == ST_POST));
    assign w_trig_take = iw_trig && !iw_arm && (r_state == ST_ARMED);
    assign w_pop       = iw_rd_en && !iw_arm && (r_state == ST_DONE) && (r_count != '0);
    assign w_post_ld   = (iw_post > c_post_max) ? c_post_max : iw_post;

    // Oldest entry is always wr_ptr - count, so popping needs no separate read pointer.
    assign w_rd_addr   = r_wr_ptr - r_count[c_aw-1:0];

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARMED: begin
                if (w_trig_take) begin
                    w_state_nxt = (w_post_ld == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (w_capture && (r_post == c_cw'(1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = r_state;
        endcase
        if (iw_arm) begin
            w_state_nxt = ST_ARMED;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst || iw_arm) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
                if (r_count == c_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + c_cw'(1);
                end
            end
            if (w_pop) begin
                r_count <= r_count - c_cw'(1);
            end
            if (w_trig_take) begin
                r_post <= w_post_ld;
            end else if (w_capture && (r_state == ST_POST)) begin
                r_post <= r_post - c_cw'(1);
            end
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
        end
    end

    diad_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_ew)
    ) u_ram (
        .clk   (iw_clk),
        .rst   (iw_rst),
        .we    (w_capture),
        .waddr (r_wr_ptr),
        .wdata ({r_tick, iw_pc, iw_instr}),
        .re    (w_pop),
        .raddr (w_rd_addr),
        .rdata (w_rd_entry)
    );

    assign {ow_rd_tick, ow_rd_pc, ow_rd_instr} = w_rd_entry;
    assign ow_rd_valid = r_rd_valid;
    assign ow_state    = r_state;
    assign ow_count    = r_count;
    assign ow_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_diad_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_diad_trace_buf
// Purpose  : Scoreboard bench for diad_trace_buf against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_diad_trace_buf;

    localparam int PC_W    = 24;
    localparam int INSTR_W = 24;
    localparam int DEPTH   = 16;
    localparam int TICK_W  = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, valid, arm, trig, rd_en;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [CW-1:0]      post;
`ifdef DIAD_TRACE_FILTER_EN
    logic [PC_W-1:0]    pc_lo, pc_hi;
`endif
    logic               rd_valid, overflow;
    logic [PC_W-1:0]    rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic [TICK_W-1:0]  rd_tick;
    logic [1:0]         state;
    logic [CW-1:0]      count;

    diad_trace_buf #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .TICK_W(TICK_W)
    ) dut (
        .iw_clk      (clk),
        .iw_rst      (rst),
        .iw_valid    (valid),
        .iw_pc       (pc),
        .iw_instr    (instr),
`ifdef DIAD_TRACE_FILTER_EN
        .iw_pc_lo    (pc_lo),
        .iw_pc_hi    (pc_hi),
`endif
        .iw_arm      (arm),
        .iw_trig     (trig),
        .iw_post     (post),
        .iw_rd_en    (rd_en),
        .ow_rd_valid (rd_valid),
        .ow_rd_pc    (rd_pc),
        .ow_rd_instr (rd_instr),
        .ow_rd_tick  (rd_tick),
        .ow_state    (state),
        .ow_count    (count),
        .ow_overflow (overflow)
    );

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [TICK_W-1:0]  tick;
    } ent_t;

    // Reference model: mode 0..3 = IDLE/ARMED/POST/DONE
    ent_t              m_buf[$];
    ent_t              m_exp[$];
    int                m_mode = 0;
    int                m_post = 0;
    bit                m_ovf = 1'b0;
    bit                m_popped = 1'b0;
    logic [TICK_W-1:0] m_tick = '0;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [PC_W-1:0]   last_pc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit in_window(input logic [PC_W-1:0] p);
`ifdef DIAD_TRACE_FILTER_EN
        return (p >= pc_lo) && (p <= pc_hi);
`else
        return (p == p);
`endif
    endfunction

    task automatic capture(input logic [TICK_W-1:0] t);
        ent_t e;
        e.pc = pc; e.instr = instr; e.tick = t;
        m_buf.push_back(e);
        if (m_buf.size() > DEPTH) begin
            m_buf.delete(0);
            m_ovf = 1'b1;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_eval();
        logic [TICK_W-1:0] cap;
        m_popped = 1'b0;
        if (rst) begin
            m_mode = 0; m_buf.delete(); m_ovf = 1'b0; m_post = 0; m_tick = '0;
            return;
        end
        cap = m_tick;
        m_tick = m_tick + 1'b1;
        if (arm) begin
            m_mode = 1; m_buf.delete(); m_ovf = 1'b0; m_post = 0;
            return;
        end
        case (m_mode)
            1: begin
                if (valid && in_window(pc)) capture(cap);
                if (trig) begin
                    m_post = (int'(post) > DEPTH - 1) ? DEPTH - 1 : int'(post);
                    m_mode = (m_post == 0) ? 3 : 2;
                end
            end
            2: begin
                if (valid && in_window(pc)) begin
                    capture(cap);
                    m_post--;
                    if (m_post == 0) m_mode = 3;
                end
            end
            3: begin
                if (rd_en && m_buf.size() > 0) begin
                    m_exp.push_back(m_buf.pop_front());
                    m_popped = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic idle_inputs();
        rst = 1'b0; valid = 1'b0; arm = 1'b0; trig = 1'b0; rd_en = 1'b0;
    endtask

    task automatic cyc();
        model_eval();
        @(posedge clk);
        #1;
        chk("state", state, m_mode);
        chk("count", count, m_buf.size());
        chk("overflow", overflow, m_ovf);
        chk("rd_valid", rd_valid, m_popped);
        idle_inputs();
    endtask

    task automatic retire(input logic [PC_W-1:0] p, input bit t, input int pst);
        valid = 1'b1; pc = p; instr = INSTR_W'($urandom); trig = t; post = CW'(pst);
        cyc();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            cyc();
        end
        cyc();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge clk) begin
        ent_t e;
        if (rd_valid === 1'b1) begin
            if (m_exp.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd_unexpected: ow_rd_valid=1 with pc 0x%0h, expected no read data", rd_pc);
            end else begin
                e = m_exp.pop_front();
                chk("rd_pc", rd_pc, e.pc);
                chk("rd_instr", rd_instr, e.instr);
                chk("rd_tick", rd_tick, e.tick);
                last_pc = rd_pc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at 500000, expected to finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        pc = '0; instr = '0; post = '0;
`ifdef DIAD_TRACE_FILTER_EN
        pc_lo = '0; pc_hi = '1;
`endif
        for (int i = 0; i < 3; i++) begin rst = 1'b1; cyc(); end
        chk("rst_rd_pc", rd_pc, 0);
        chk("rst_rd_instr", rd_instr, 0);
        chk("rst_rd_tick", rd_tick, 0);

        // Five retirements, trigger with post=0 on the last
        arm = 1'b1; cyc();
        for (int k = 0; k < 5; k++) retire(PC_W'(k), k == 4, 0);
        chk("s1_state", state, 3);
        chk("s1_count", count, 5);
        chk("s1_overflow", overflow, 0);
        drain(5);
        chk("s1_last_pc", last_pc, 4);

        // Twenty retirements wrap the 16-entry buffer
        arm = 1'b1; cyc();
        for (int k = 1; k <= 20; k++) retire(PC_W'(k), k == 20, 0);
        chk("s2_count", count, 16);
        chk("s2_overflow", overflow, 1);
        drain(16);
        chk("s2_last_pc", last_pc, 20);

        // Post-trigger capture of 3 with valid on alternating cycles
        arm = 1'b1; cyc();
        for (int k = 1; k <= 13; k++) begin
            retire(PC_W'(k), k == 10, 3);
            if (k == 12) chk("s3_state_post", state, 2);
            cyc();
        end
        chk("s3_state_done", state, 3);
        chk("s3_count", count, 13);
        drain(13);
        chk("s3_last_pc", last_pc, 13);

        // Over-read: 4 pops requested, only 2 entries held
        arm = 1'b1; cyc();
        retire(24'h000aa1, 1'b0, 0);
        retire(24'h000aa2, 1'b1, 0);
        drain(4);
        chk("s4_count", count, 0);
        chk("s4_last_pc", last_pc, 24'h000aa2);

        // Arm with same-cycle trig, then reset during POST
        arm = 1'b1; cyc();
        retire(24'h000111, 1'b1, 5);
        chk("s5_post", state, 2);
        arm = 1'b1; trig = 1'b1; cyc();
        chk("s5_arm_state", state, 1);
        chk("s5_arm_count", count, 0);
        retire(24'h000222, 1'b1, 5);
        retire(24'h000333, 1'b0, 0);
        rst = 1'b1; cyc();
        chk("s5_rst_state", state, 0);
        chk("s5_rst_count", count, 0);
        chk("s5_rst_rd_pc", rd_pc, 0);
        chk("s5_rst_rd_instr", rd_instr, 0);
        chk("s5_rst_rd_tick", rd_tick, 0);

`ifdef DIAD_TRACE_FILTER_EN
        pc_lo = 24'h000100; pc_hi = 24'h0001ff;
        arm = 1'b1; cyc();
        retire(24'h0000ff, 1'b0, 0);
        retire(24'h000100, 1'b0, 0);
        retire(24'h0001ff, 1'b0, 0);
        retire(24'h000200, 1'b1, 0);
        chk("flt_count", count, 2);
        drain(2);
        chk("flt_last_pc", last_pc, 24'h0001ff);
        pc_lo = '0; pc_hi = '1;
`endif

        // Randomized rounds against the model
        for (int r = 0; r < 30; r++) begin
            int trig_after;
            arm = 1'b1; cyc();
            trig_after = $urandom_range(0, 25);
            for (int c = 0; c < 80 && m_mode != 3; c++) begin
                valid = ($urandom_range(0, 3) != 0);
                pc    = PC_W'($urandom);
                instr = INSTR_W'($urandom);
                post  = CW'($urandom_range(0, 31));
                trig  = (c >= trig_after) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
                rd_en = ($urandom_range(0, 7) == 0);
                arm   = ($urandom_range(0, 99) == 0);
                rst   = ($urandom_range(0, 299) == 0);
                cyc();
            end
            for (int c = 0; c < 60 && m_buf.size() > 0; c++) begin
                rd_en = ($urandom_range(0, 3) != 0);
                valid = $urandom_range(0, 1) == 1;
                pc    = PC_W'($urandom);
                trig  = $urandom_range(0, 1) == 1;
                cyc();
            end
            cyc();
        end

        cyc(); cyc();
        chk("scoreboard_empty", m_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
